wash_sequencer: RTL and testbench

Program sequencer for the washing-machine controller. It steps through the phases WASH → RINSE → SPIN → DONE, timing each phase in whole seconds from a one-cycle `sec_tick` strobe produced by the seconds divider. It owns the divider's enable (`div_en`), drives the actuator outputs, and exposes the remaining time per phase and in total for the seven-segment display path.

---
 rtl/wash_sequencer.sv | 130 +++++++++++++
 tb/tb_wash_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: WASH -> RINSE -> SPIN -> DONE, timed in
// seconds from sec_tick, with pause/resume and registered actuator outputs.
module wash_sequencer #(
  parameter int WASH_T  = 9,
  parameter int RINSE_T = 6,
  parameter int SPIN_T  = 3,
  parameter int ALARM_T = 5,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_pause,
  input  logic          sec_tick,
  output logic          div_en,
  output logic [2:0]    phase,
  output logic          paused,
  output logic [CW-1:0] remain,
  output logic [CW-1:0] total_left,
  output logic          water_in,
  output logic          motor,
  output logic          drain,
  output logic          alarm
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WASH  = 3'd1,
    S_RINSE = 3'd2,
    S_SPIN  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          paused_d;
  logic [CW-1:0] remain_d, total_d;
  logic          tick_ok;
  logic          run_d;
  logic          div_en_d, water_d, motor_d, drain_d, alarm_d;

  // The phase output doubles as the debug view of the FSM state.
  assign phase = state_q;

  // Handshake: start_pause and sec_tick are single-cycle strobes sampled on
  // the rising edge; no ready is returned, every strobe is consumed or dropped.
  // A tick is only meaningful while the divider is enabled.
  assign tick_ok = sec_tick && div_en;

  always_comb begin
    state_d  = state_q;
    paused_d = paused;
    remain_d = remain;
    total_d  = total_left;
    case (state_q)
      S_IDLE: begin
        if (start_pause) begin
          state_d  = S_WASH;
          paused_d = 1'b0;
          remain_d = CW'(WASH_T);
          total_d  = CW'(WASH_T + RINSE_T + SPIN_T);
        end
      end
      S_WASH, S_RINSE, S_SPIN: begin
        if (start_pause) begin
          paused_d = !paused;
        end else if (tick_ok) begin
          total_d = total_left - CW'(1);
          if (remain == CW'(1)) begin
            case (state_q)
              S_WASH:  begin state_d = S_RINSE; remain_d = CW'(RINSE_T); end
              S_RINSE: begin state_d = S_SPIN;  remain_d = CW'(SPIN_T);  end
              default: begin state_d = S_DONE;  remain_d = CW'(ALARM_T); end
            endcase
          end else begin
            remain_d = remain - CW'(1);
          end
        end
      end
      S_DONE: begin
        if (start_pause || (tick_ok && remain == CW'(1))) begin
          state_d  = S_IDLE;
          paused_d = 1'b0;
          remain_d = '0;
          total_d  = '0;
        end else if (tick_ok) begin
          remain_d = remain - CW'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        paused_d = 1'b0;
        remain_d = '0;
        total_d  = '0;
      end
    endcase

    // Outputs are computed from the next state so the registers show them
    // in the same cycle as the phase they belong to.
    run_d    = (state_d == S_WASH || state_d == S_RINSE || state_d == S_SPIN) && !paused_d;
    water_d  = run_d && (state_d == S_WASH || state_d == S_RINSE);
    motor_d  = run_d;
    drain_d  = run_d && (state_d == S_SPIN);
    alarm_d  = (state_d == S_DONE);
    div_en_d = run_d || (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      paused     <= 1'b0;
      remain     <= '0;
      total_left <= '0;
      div_en     <= 1'b0;
      water_in   <= 1'b0;
      motor      <= 1'b0;
      drain      <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state_q    <= state_d;
      paused     <= paused_d;
      remain     <= remain_d;
      total_left <= total_d;
      div_en     <= div_en_d;
      water_in   <= water_d;
      motor      <= motor_d;
      drain      <= drain_d;
      alarm      <= alarm_d;
    end
  end

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: directed scenarios plus randomized traffic compared
// against a phase/duration-table model of the washing program.
module tb_wash_sequencer;

  localparam int WASH_T  = 3;
  localparam int RINSE_T = 2;
  localparam int SPIN_T  = 2;
  localparam int ALARM_T = 2;
  localparam int CW      = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_pause = 1'b0;
  logic          sec_tick = 1'b0;
  logic          div_en;
  logic [2:0]    phase;
  logic          paused;
  logic [CW-1:0] remain;
  logic [CW-1:0] total_left;
  logic          water_in, motor, drain, alarm;

  int n_tests = 0;
  int n_fail  = 0;

  wash_sequencer #(
    .WASH_T(WASH_T), .RINSE_T(RINSE_T), .SPIN_T(SPIN_T), .ALARM_T(ALARM_T), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .start_pause(start_pause), .sec_tick(sec_tick),
    .div_en(div_en), .phase(phase), .paused(paused), .remain(remain),
    .total_left(total_left), .water_in(water_in), .motor(motor),
    .drain(drain), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Reference model: phase index 0..4 with a table of phase durations.
  int dur [5] = '{0, WASH_T, RINSE_T, SPIN_T, ALARM_T};
  int m_phase  = 0;
  bit m_paused = 1'b0;
  int m_remain = 0;
  int m_total  = 0;

  function automatic bit m_running();
    return (m_phase >= 1) && (m_phase <= 3) && !m_paused;
  endfunction

  function automatic logic [24:0] exp_vec();
    bit run;
    bit de;
    run = m_running();
    de  = run || (m_phase == 4);
    return {de, 3'(m_phase), m_paused, 8'(m_remain), 8'(m_total),
            run && (m_phase <= 2), run, run && (m_phase == 3), m_phase == 4};
  endfunction

  function automatic logic [24:0] got_vec();
    return {div_en, phase, paused, remain, total_left, water_in, motor, drain, alarm};
  endfunction

  task automatic model_step(input bit sp, input bit tk, input bit r);
    bit tick_eff;
    tick_eff = tk && (m_running() || m_phase == 4);
    if (r) begin
      m_phase = 0; m_paused = 0; m_remain = 0; m_total = 0;
    end else if (m_phase == 0) begin
      if (sp) begin
        m_phase = 1; m_paused = 0; m_remain = dur[1];
        m_total = dur[1] + dur[2] + dur[3];
      end
    end else if (m_phase <= 3) begin
      if (sp) m_paused = !m_paused;
      else if (tick_eff) begin
        m_total = m_total - 1;
        if (m_remain == 1) begin
          m_phase  = m_phase + 1;
          m_remain = dur[m_phase];
        end else m_remain = m_remain - 1;
      end
    end else begin
      if (sp || (tick_eff && m_remain == 1)) begin
        m_phase = 0; m_paused = 0; m_remain = 0; m_total = 0;
      end else if (tick_eff) m_remain = m_remain - 1;
    end
  endtask

  // Drive one clock cycle of inputs and advance the model in step.
  task automatic cycle(input bit sp, input bit tk, input bit r);
    start_pause = sp;
    sec_tick    = tk;
    rst         = r;
    model_step(sp, tk, r);
    @(posedge clk);
    #1;
    start_pause = 1'b0;
    sec_tick    = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  task automatic test_reset();
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    n_tests++;
    if (got_vec() !== 25'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", got_vec(), 25'h0);
    end
  endtask

  task automatic test_idle_immunity();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0);
      idle(2);
      n_tests++;
      if (got_vec() !== 25'h0) begin
        n_fail++;
        $display("FAIL idle_immunity tick %0d: got %h expected %h", i, got_vec(), 25'h0);
      end
    end
  endtask

  task automatic test_full_program();
    int exp_phase [10] = '{1, 1, 1, 2, 2, 3, 3, 4, 4, 0};
    int exp_total [10] = '{7, 6, 5, 4, 3, 2, 1, 0, 0, 0};
    int alarm_secs = 0;
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    n_tests++;
    if (phase !== 3'(exp_phase[0]) || total_left !== 8'(exp_total[0])) begin
      n_fail++;
      $display("FAIL full_start: phase %0d total %0d expected %0d %0d",
               phase, total_left, exp_phase[0], exp_total[0]);
    end
    for (int k = 1; k <= 9; k++) begin
      idle(9);
      cycle(0, 1, 0);
      if (alarm === 1'b1) alarm_secs++;
      n_tests++;
      if (phase !== 3'(exp_phase[k]) || total_left !== 8'(exp_total[k])) begin
        n_fail++;
        $display("FAIL full_tick %0d: phase %0d total %0d expected %0d %0d",
                 k, phase, total_left, exp_phase[k], exp_total[k]);
      end
      n_tests++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL full_model tick %0d: got %h expected %h", k, got_vec(), exp_vec());
      end
    end
    n_tests++;
    if (alarm_secs !== 2 || div_en !== 1'b0) begin
      n_fail++;
      $display("FAIL full_end: alarm_secs %0d div_en %b expected 2 0", alarm_secs, div_en);
    end
  endtask

  task automatic test_pause_hold();
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      idle(2);
      cycle(0, 1, 0);
      n_tests++;
      if (paused !== 1'b1 || remain !== 8'd2 || motor !== 1'b0 ||
          water_in !== 1'b0 || div_en !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_hold %0d: paused %b remain %0d motor %b water %b div_en %b expected 1 2 0 0 0",
                 i, paused, remain, motor, water_in, div_en);
      end
    end
    cycle(1, 0, 0);
    idle(2);
    cycle(0, 1, 0);
    n_tests++;
    if (paused !== 1'b0 || remain !== 8'd1 || motor !== 1'b1 || phase !== 3'd1) begin
      n_fail++;
      $display("FAIL pause_resume: paused %b remain %0d motor %b phase %0d expected 0 1 1 1",
               paused, remain, motor, phase);
    end
  endtask

  task automatic test_simultaneous();
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    cycle(1, 1, 0);
    n_tests++;
    if (phase !== 3'd2 || paused !== 1'b1 || remain !== 8'd2) begin
      n_fail++;
      $display("FAIL simul_pause: phase %0d paused %b remain %0d expected 2 1 2", phase, paused, remain);
    end
    cycle(1, 1, 0);
    n_tests++;
    if (paused !== 1'b0 || remain !== 8'd2 || total_left !== 8'd4) begin
      n_fail++;
      $display("FAIL simul_resume: paused %b remain %0d total %0d expected 0 2 4", paused, remain, total_left);
    end
  endtask

  task automatic test_early_ack();
    // Continues from RINSE with remain 2: four ticks reach DONE.
    for (int i = 0; i < 4; i++) cycle(0, 1, 0);
    n_tests++;
    if (phase !== 3'd4 || remain !== 8'd2 || alarm !== 1'b1) begin
      n_fail++;
      $display("FAIL early_done: phase %0d remain %0d alarm %b expected 4 2 1", phase, remain, alarm);
    end
    cycle(1, 0, 0);
    n_tests++;
    if (phase !== 3'd0 || alarm !== 1'b0 || remain !== 8'd0 || div_en !== 1'b0) begin
      n_fail++;
      $display("FAIL early_ack: phase %0d alarm %b remain %0d div_en %b expected 0 0 0 0",
               phase, alarm, remain, div_en);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0);
    cycle(1, 0, 0);
    n_tests++;
    if (phase !== 3'd3 || paused !== 1'b1 || drain !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_setup: phase %0d paused %b drain %b expected 3 1 0", phase, paused, drain);
    end
    cycle(1, 1, 1);
    n_tests++;
    if (got_vec() !== 25'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h expected %h", got_vec(), 25'h0);
    end
    cycle(1, 0, 0);
    n_tests++;
    if (phase !== 3'd1 || remain !== 8'd3 || total_left !== 8'd7) begin
      n_fail++;
      $display("FAIL reset_restart: phase %0d remain %0d total %0d expected 1 3 7", phase, remain, total_left);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1, 0, 0);
    n_tests++;
    if (paused !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_pause: paused %b expected 1", paused);
    end
    cycle(1, 0, 0);
    n_tests++;
    if (paused !== 1'b0 || motor !== 1'b1 || div_en !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_resume: paused %b motor %b div_en %b expected 0 1 1", paused, motor, div_en);
    end
  endtask

  task automatic test_random();
    bit sp, tk, r;
    for (int i = 0; i < 1500; i++) begin
      sp = ($urandom_range(0, 11) == 0);
      tk = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 299) == 0);
      cycle(sp, tk, r);
      n_tests++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h expected %h", i, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_immunity();
    test_full_program();
    test_pause_hold();
    test_simultaneous();
    test_early_ack();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
